banco_registradores: RTL and testbench
======================================

# banco_registradores

Eight-entry, 16-bit register storage that feeds the bank's 8:1 read multiplexer. Each stored word is driven continuously on its own output, saida0..saida7, and these connect one-to-one to the multiplexer's entrada0..entrada7. The block has one write port with a valid/ready handshake. It also has a clear sequencer that zeroes the bank one register per cycle.

## Interface
- LARGURA, default 16: data width of each register and each output.
- clock  input  1  the single clock; all state updates on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- escrita_valida  input  1  write request is valid this cycle.
- escrita_pronta  output  1  block can accept a write this cycle.
- endereco  input  3  target register index, 0..7.
- dado  input  LARGURA  write data.
- limpar  input  1  request to clear the whole bank.
- ocupado  output  1  clear sequence in progress.
- saida0 .. saida7  output  LARGURA each  registered contents of registers 0..7.

## Operation
- Storage:
  - 8 registers, reg[0..7], each LARGURA bits.
  - saidaN = reg[N] at all times, taken straight from the flops with no output logic.
- States:
  - OCIOSO (idle).
  - LIMPANDO (clearing), with a 3-bit index idx.
- Handshake:
  - escrita_pronta = (estado == OCIOSO) && !limpar. This is combinational.
  - A write is accepted on a rising edge where escrita_valida && escrita_pronta. At that edge, reg[endereco] <= dado.
  - All other registers hold their values.
  - escrita_valida while escrita_pronta=0 has no effect. The writer holds endereco/dado until the write is accepted; the block keeps no write buffer.
- OCIOSO:
  - On an edge with limpar=1, go to LIMPANDO with idx <= 0. No write is accepted on that edge, because escrita_pronta is already 0.
  - Otherwise stay in OCIOSO.
- LIMPANDO:
  - Each edge does reg[idx] <= 0 and idx <= idx+1.
  - On the edge that clears idx=7, return to OCIOSO. idx wraps to 0.
  - limpar is ignored while in LIMPANDO. There is no restart and no extension.
  - escrita_valida is ignored; writes are not queued.
- ocupado = (estado == LIMPANDO).
- Width rules:
  - endereco is a full 3 bits, so every value is a legal index.
  - dado is stored unmodified; there is no sign or zero extension.

## Timing
- Reset (reset_n=0, asynchronous):
  - All reg = 0, so saida0..7 = 0.
  - estado = OCIOSO, idx = 0, ocupado = 0.
  - escrita_pronta = !limpar.
  - Reset takes effect immediately, without waiting for a clock edge.
- Reset release: the first rising edge with reset_n=1 can accept a write.
- Write latency: new data appears on saidaN immediately after the accepting edge (1 cycle, no extra pipeline).
- Clear duration:
  - The edge that samples limpar=1 makes ocupado go high.
  - 8 further edges clear reg0..reg7 in order.
  - After the 8th clearing edge, ocupado is 0 and escrita_pronta follows !limpar.
  - The earliest next write is accepted on edge 9 after the sampling edge.
- Partial clear: during LIMPANDO, registers with index >= idx still show their old values. Each output reads 0 from the cycle after its own clearing edge.
- limpar held high continuously starts a new clear each time the block returns to OCIOSO. The bank then never accepts writes until limpar drops.
- Reset during LIMPANDO aborts the sequence: all registers go to 0 and the state goes to OCIOSO.
- Back-to-back writes are legal, one per cycle, including repeated writes to the same address. The last write wins.

## Test plan
- Reset behaviour:
  - Stimulus: assert reset_n=0 mid-cycle with a non-zero bank.
  - Response: saida0..7 = 0 before the next edge; ocupado=0; escrita_pronta=1.
- Write to every address:
  - Stimulus: write 16'h1110+N to address N for N=0..7 on consecutive cycles.
  - Response: each saidaN = 16'h1110+N one cycle after its write; all other outputs unchanged.
- Blocked write:
  - Stimulus: assert limpar and escrita_valida together with endereco=3, dado=16'hBEEF.
  - Response: escrita_pronta=0; reg3 is not written; clear starts; ocupado=1 for exactly 8 cycles.
- Clear order:
  - Stimulus: load all registers with 16'hFFFF, then pulse limpar for 1 cycle.
  - Response: saidaK reads 0 from cycle K+1 after the sampling edge while saida(K+1..7) still read 16'hFFFF; a write held pending during the clear is accepted on edge 9.
- Reset mid-clear:
  - Stimulus: assert reset_n=0 at the 4th clearing cycle.
  - Response: all outputs 0; ocupado=0 immediately; after release, a write to address 7 of 16'h00A5 is accepted on the first edge.
- Write collision:
  - Stimulus: write 16'h0001 then 16'h0002 to address 5 on back-to-back cycles.
  - Response: saida5 shows 16'h0001 for one cycle, then 16'h0002.

Source files
------------

// File: rtl/banco_registradores.sv
// Eight-entry register bank feeding the 8:1 read mux.
// One handshaked write port plus a one-per-cycle clear sequencer.
module banco_registradores #(
    parameter int LARGURA = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               escrita_valida,
    output logic               escrita_pronta,
    input  logic [2:0]         endereco,
    input  logic [LARGURA-1:0] dado,
    input  logic               limpar,
    output logic               ocupado,
    output logic [LARGURA-1:0] saida0,
    output logic [LARGURA-1:0] saida1,
    output logic [LARGURA-1:0] saida2,
    output logic [LARGURA-1:0] saida3,
    output logic [LARGURA-1:0] saida4,
    output logic [LARGURA-1:0] saida5,
    output logic [LARGURA-1:0] saida6,
    output logic [LARGURA-1:0] saida7
);

    typedef enum logic {
        OCIOSO,
        LIMPANDO
    } estado_t;

    estado_t            estado;
    estado_t            prox_estado;
    logic [2:0]         idx;
    logic [2:0]         prox_idx;
    logic [LARGURA-1:0] regs [8];
    logic               aceita;

    assign escrita_pronta = (estado == OCIOSO) && !limpar;
    assign ocupado        = (estado == LIMPANDO);
    assign aceita         = escrita_valida && escrita_pronta;

    // State and clear-index register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            idx    <= 3'd0;
        end else begin
            estado <= prox_estado;
            idx    <= prox_idx;
        end
    end

    // Next state: idle waits for limpar, clearing walks idx 0..7 then returns
    always_comb begin
        prox_estado = estado;
        prox_idx    = idx;
        unique case (estado)
            OCIOSO: begin
                if (limpar) begin
                    prox_estado = LIMPANDO;
                    prox_idx    = 3'd0;
                end
            end
            LIMPANDO: begin
                prox_idx = idx + 3'd1;
                if (idx == 3'd7) begin
                    prox_estado = OCIOSO;
                end
            end
            default: begin
                prox_estado = OCIOSO;
                prox_idx    = 3'd0;
            end
        endcase
    end

    // Storage: clear has priority; writes only land while idle and ready
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (estado == LIMPANDO) begin
            regs[idx] <= '0;
        end else if (aceita) begin
            regs[endereco] <= dado;
        end
    end

    assign saida0 = regs[0];
    assign saida1 = regs[1];
    assign saida2 = regs[2];
    assign saida3 = regs[3];
    assign saida4 = regs[4];
    assign saida5 = regs[5];
    assign saida6 = regs[6];
    assign saida7 = regs[7];

endmodule

// File: tb/tb_banco_registradores.sv
// Bench for banco_registradores: vector table, corner sequences,
// and random traffic against a bank-level reference model.
module tb_banco_registradores;

    logic        clock;
    logic        reset_n;
    logic        escrita_valida;
    logic        escrita_pronta;
    logic [2:0]  endereco;
    logic [15:0] dado;
    logic        limpar;
    logic        ocupado;
    logic [15:0] saida0, saida1, saida2, saida3;
    logic [15:0] saida4, saida5, saida6, saida7;

    wire  [15:0] s [8];
    assign s[0] = saida0;
    assign s[1] = saida1;
    assign s[2] = saida2;
    assign s[3] = saida3;
    assign s[4] = saida4;
    assign s[5] = saida5;
    assign s[6] = saida6;
    assign s[7] = saida7;

    banco_registradores #(.LARGURA(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .escrita_valida (escrita_valida),
        .escrita_pronta (escrita_pronta),
        .endereco       (endereco),
        .dado           (dado),
        .limpar         (limpar),
        .ocupado        (ocupado),
        .saida0         (saida0),
        .saida1         (saida1),
        .saida2         (saida2),
        .saida3         (saida3),
        .saida4         (saida4),
        .saida5         (saida5),
        .saida6         (saida6),
        .saida7         (saida7)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bank contents, clear-in-progress flag, words cleared
    logic [15:0] m_mem [8];
    bit          m_busy;
    int          m_cnt;

    typedef struct {
        bit          v;
        logic [2:0]  a;
        logic [15:0] d;
        bit          l;
        bit          exp_pr;
        logic [2:0]  ca;
        logic [15:0] ev;
        bit          eo;
    } vec_t;

    vec_t tab [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0;
        m_busy = 0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        if (m_busy) begin
            m_mem[m_cnt] = 16'h0;
            m_cnt++;
            if (m_cnt == 8) begin
                m_busy = 0;
                m_cnt  = 0;
            end
        end else if (limpar) begin
            m_busy = 1;
            m_cnt  = 0;
        end else if (escrita_valida) begin
            m_mem[endereco] = dado;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_saida%0d", tag, i), 32'(s[i]), 32'(m_mem[i]));
        end
        chk({tag, "_ocupado"}, 32'(ocupado), 32'(m_busy));
        chk({tag, "_pronta"}, 32'(escrita_pronta),
            32'(!m_busy && !limpar));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        escrita_valida = 0;
        limpar         = 0;
        endereco       = 3'd0;
        dado           = 16'h0;
    endtask

    int ocnt;

    initial begin
        idle_in();
        reset_n = 0;
        model_reset();
        #2;
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_pronta", 32'(escrita_pronta), 32'd1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rst_saida%0d", i), 32'(s[i]), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1;

        // Vector table: write every address, then a same-address collision
        for (int n = 0; n < 8; n++) begin
            tab[n] = '{1'b1, 3'(n), 16'h1110 + 16'(n), 1'b0,
                       1'b1, 3'(n), 16'h1110 + 16'(n), 1'b0};
        end
        tab[8] = '{1'b1, 3'd5, 16'h0001, 1'b0, 1'b1, 3'd5, 16'h0001, 1'b0};
        tab[9] = '{1'b1, 3'd5, 16'h0002, 1'b0, 1'b1, 3'd5, 16'h0002, 1'b0};
        for (int k = 0; k < 10; k++) begin
            escrita_valida = tab[k].v;
            endereco       = tab[k].a;
            dado           = tab[k].d;
            limpar         = tab[k].l;
            #1;
            chk($sformatf("vec%0d_pronta", k), 32'(escrita_pronta),
                32'(tab[k].exp_pr));
            tick();
            chk($sformatf("vec%0d_val", k), 32'(s[tab[k].ca]),
                32'(tab[k].ev));
            chk($sformatf("vec%0d_ocup", k), 32'(ocupado), 32'(tab[k].eo));
            check_all($sformatf("vec%0d", k));
        end
        idle_in();

        // Async reset mid-cycle with a non-zero bank
        #3;
        reset_n = 0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst_s5", 32'(saida5), 32'd0);
        #1;
        reset_n = 1;
        @(posedge clock);
        #1;

        // Blocked write: limpar and escrita_valida together
        escrita_valida = 1;
        endereco       = 3'd3;
        dado           = 16'hBEEF;
        tick();
        idle_in();
        chk("pre_blk_s3", 32'(saida3), 32'hBEEF);
        escrita_valida = 1;
        endereco       = 3'd3;
        dado           = 16'h1234;
        limpar         = 1;
        #1;
        chk("blk_pronta", 32'(escrita_pronta), 32'd0);
        tick();
        idle_in();
        chk("blk_s3_kept", 32'(saida3), 32'hBEEF);
        ocnt = 0;
        for (int c = 0; c < 20 && ocupado; c++) begin
            ocnt++;
            check_all("blk");
            tick();
        end
        chk("blk_busy_cycles", 32'(ocnt), 32'd8);
        chk("blk_s3_cleared", 32'(saida3), 32'd0);

        // Clear order with a write held pending across the clear
        for (int n = 0; n < 8; n++) begin
            escrita_valida = 1;
            endereco       = 3'(n);
            dado           = 16'hFFFF;
            tick();
        end
        idle_in();
        limpar = 1;
        tick();
        limpar         = 0;
        escrita_valida = 1;
        endereco       = 3'd2;
        dado           = 16'h1234;
        for (int k = 0; k < 8; k++) begin
            tick();
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("ord%0d_s%0d", k, j), 32'(s[j]),
                    (j <= k) ? 32'd0 : 32'hFFFF);
            end
            chk($sformatf("ord%0d_ocup", k), 32'(ocupado),
                (k == 7) ? 32'd0 : 32'd1);
        end
        chk("ord_pronta_after", 32'(escrita_pronta), 32'd1);
        tick();
        chk("ord_edge9_write", 32'(saida2), 32'h1234);
        idle_in();

        // Reset during the 4th clearing cycle, then write on first edge
        limpar = 1;
        tick();
        limpar = 0;
        for (int k = 0; k < 3; k++) tick();
        chk("mid_busy", 32'(ocupado), 32'd1);
        #3;
        reset_n = 0;
        model_reset();
        #1;
        check_all("mid_rst");
        #1;
        reset_n        = 1;
        escrita_valida = 1;
        endereco       = 3'd7;
        dado           = 16'h00A5;
        tick();
        chk("mid_first_write", 32'(saida7), 32'h00A5);
        check_all("mid_after");
        idle_in();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            escrita_valida = 1'($urandom_range(0, 1));
            endereco       = 3'($urandom);
            dado           = 16'($urandom);
            limpar         = ($urandom_range(0, 15) == 0);
            #1;
            chk($sformatf("rnd%0d_pre_pronta", c), 32'(escrita_pronta),
                32'(!m_busy && !limpar));
            tick();
            check_all($sformatf("rnd%0d", c));
        end
        idle_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
